// File: rtl/ifetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues single-outstanding imem reads,
// buffers returned words in a small prefetch queue. Define IFETCH_PERF_EN for perf counters.
module ifetch_queue #(
    parameter int          PC_W     = 10,
    parameter int          INSTR_W  = 32,
    parameter int          DEPTH    = 2,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               inst_valid,
    output logic [INSTR_W-1:0] inst_data,
    output logic [PC_W-1:0]    inst_pc,
    input  logic               inst_ready
`ifdef IFETCH_PERF_EN
    ,
    output logic [15:0]        perf_inst,
    output logic [15:0]        perf_flush
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic {FETCH, DISCARD} state_t;

    state_t             state, state_n;
    logic [PC_W-1:0]    fetch_pc, fetch_pc_n;
    logic [PC_W-1:0]    discard_addr, discard_addr_n;
    logic               req_q, req_n;
    logic [CNT_W-1:0]   count, count_n;
    logic [PTR_W-1:0]   rd_ptr, rd_ptr_n, wr_ptr, wr_ptr_n;
    logic               push, pop;

    logic [INSTR_W-1:0] mem_data [DEPTH];
    logic [PC_W-1:0]    mem_pc   [DEPTH];

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_n        = state;
        fetch_pc_n     = fetch_pc;
        discard_addr_n = discard_addr;
        req_n          = req_q;
        count_n        = count;
        rd_ptr_n       = rd_ptr;
        wr_ptr_n       = wr_ptr;
        push           = 1'b0;
        pop            = (count != '0) && inst_ready;

        if (redirect_valid) begin
            fetch_pc_n = redirect_pc;
            count_n    = '0;
            rd_ptr_n   = '0;
            wr_ptr_n   = '0;
            req_n      = 1'b1;
            if (state == FETCH && req_q && !imem_ack) begin
                state_n        = DISCARD;
                discard_addr_n = fetch_pc;
            end else if (state == DISCARD && imem_ack) begin
                state_n = FETCH;
            end
        end else if (state == DISCARD) begin
            // The wrong-path word is dropped; the next request issues straight after its ack.
            if (imem_ack) state_n = FETCH;
        end else begin
            push = req_q && imem_ack;
            if (pop)  rd_ptr_n = rd_ptr + PTR_W'(1);
            if (push) begin
                wr_ptr_n   = wr_ptr + PTR_W'(1);
                fetch_pc_n = fetch_pc + PC_W'(1);
            end
            count_n = count + CNT_W'(push) - CNT_W'(pop);
            if (push)        req_n = 1'b0;
            else if (!req_q) req_n = (count_n < FULL);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FETCH;
            fetch_pc     <= PC_W'(RESET_PC);
            discard_addr <= '0;
            req_q        <= 1'b0;
            count        <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
        end else begin
            state        <= state_n;
            fetch_pc     <= fetch_pc_n;
            discard_addr <= discard_addr_n;
            req_q        <= req_n;
            count        <= count_n;
            rd_ptr       <= rd_ptr_n;
            wr_ptr       <= wr_ptr_n;
        end
    end

    // NOTE: queue storage is not reset; outputs are masked to zero while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= imem_rdata;
            mem_pc[wr_ptr]   <= fetch_pc;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = (state == DISCARD) ? discard_addr : fetch_pc;
    assign inst_valid = (count != '0);
    assign inst_data  = inst_valid ? mem_data[rd_ptr] : '0;
    assign inst_pc    = inst_valid ? mem_pc[rd_ptr] : '0;

`ifdef IFETCH_PERF_EN
    logic flush_evt;
    assign flush_evt = redirect_valid &&
                       ((count != '0) || (state == FETCH && req_q && !imem_ack));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_inst  <= '0;
            perf_flush <= '0;
        end else begin
            if (pop && perf_inst != 16'hFFFF)        perf_inst  <= perf_inst + 16'd1;
            if (flush_evt && perf_flush != 16'hFFFF) perf_flush <= perf_flush + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed vector table, hand-written corner
// sequences, and a randomized run against a queue-based reference model.
module tb_ifetch_queue;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               redirect_valid = 1'b0;
    logic [PC_W-1:0]    redirect_pc = '0;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack = 1'b0;
    logic [INSTR_W-1:0] imem_rdata = '0;
    logic               inst_valid;
    logic [INSTR_W-1:0] inst_data;
    logic [PC_W-1:0]    inst_pc;
    logic               inst_ready = 1'b0;
`ifdef IFETCH_PERF_EN
    logic [15:0]        perf_inst;
    logic [15:0]        perf_flush;
`endif

    ifetch_queue #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
`ifdef IFETCH_PERF_EN
        ,
        .perf_inst      (perf_inst),
        .perf_flush     (perf_flush)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [INSTR_W-1:0] word_of(input logic [PC_W-1:0] a);
        return {a ^ 10'h3C3, 22'h2B4F1};
    endfunction

    task automatic expect_out(input string tag, input logic req, input logic [PC_W-1:0] addr,
                              input logic valid, input logic [PC_W-1:0] pc);
        check({tag, ".req"}, imem_req, req);
        if (req) check({tag, ".addr"}, imem_addr, addr);
        check({tag, ".valid"}, inst_valid, valid);
        if (valid) begin
            check({tag, ".pc"}, inst_pc, pc);
            check({tag, ".data"}, inst_data, word_of(pc));
        end
    endtask

    // Drive one cycle of inputs at a falling edge, then advance to the next falling edge.
    task automatic cyc(input logic ack, input logic [PC_W-1:0] a, input logic ready,
                       input logic rv, input logic [PC_W-1:0] rpc);
        imem_ack       = ack;
        imem_rdata     = ack ? word_of(a) : '0;
        inst_ready     = ready;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(negedge clk);
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic            ack;
        logic            ready;
        logic            exp_req;
        logic [PC_W-1:0] exp_addr;
        logic            exp_valid;
        logic [PC_W-1:0] exp_pc;
    } vec_t;

    vec_t vecs[13];

    // Reference model state
    logic [PC_W-1:0] q[$];
    logic [PC_W-1:0] m_pc, m_disc_addr;
    logic            m_req, m_disc;
    int              m_perf_inst, m_perf_flush, pops;

    initial begin
        // ---------------- Table: steady fetch, ack one cycle after req rises ----------------
        vecs[0] = '{ack: 1'b0, ready: 1'b1, exp_req: 1'b0, exp_addr: '0, exp_valid: 1'b0, exp_pc: '0};
        for (int n = 0; n < 4; n++) begin
            vecs[1 + 3*n] = '{1'b0, 1'b1, 1'b1, PC_W'(n), 1'b0, '0};
            vecs[2 + 3*n] = '{1'b1, 1'b1, 1'b1, PC_W'(n), 1'b0, '0};
            vecs[3 + 3*n] = '{1'b0, 1'b1, 1'b0, '0, 1'b1, PC_W'(n)};
        end

        do_reset();
        check("reset.inst_data", inst_data, '0);
        check("reset.inst_pc", inst_pc, '0);
        for (int i = 0; i < 13; i++) begin
            expect_out($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                       vecs[i].exp_valid, vecs[i].exp_pc);
            cyc(vecs[i].ack, vecs[i].exp_addr, vecs[i].ready, 1'b0, '0);
        end

        // ---------------- Queue fills with decode stalled ----------------
        do_reset();
        expect_out("fill.c0", 0, 0, 0, 0);      cyc(0, 0, 0, 0, 0);
        expect_out("fill.c1", 1, 0, 0, 0);      cyc(1, 0, 0, 0, 0);
        expect_out("fill.c2", 0, 0, 1, 0);      cyc(0, 0, 0, 0, 0);
        expect_out("fill.c3", 1, 1, 1, 0);      cyc(1, 1, 0, 0, 0);
        expect_out("fill.c4", 0, 0, 1, 0);      cyc(0, 0, 0, 0, 0);
        expect_out("fill.c5", 0, 0, 1, 0);      cyc(0, 0, 0, 0, 0);
        expect_out("fill.c6", 0, 0, 1, 0);      cyc(0, 0, 1, 0, 0);
        expect_out("fill.c7", 1, 2, 1, 1);

        // ---------------- Redirect while a request is outstanding ----------------
        do_reset();
        expect_out("disc.c0", 0, 0, 0, 0);      cyc(0, 0, 1, 1, 10'd5);
        expect_out("disc.c1", 1, 5, 0, 0);      cyc(0, 0, 1, 0, 0);
        expect_out("disc.c2", 1, 5, 0, 0);      cyc(0, 0, 1, 1, 10'h155);
        expect_out("disc.c3", 1, 5, 0, 0);      cyc(0, 0, 1, 0, 0);
        expect_out("disc.c4", 1, 5, 0, 0);      cyc(1, 5, 1, 0, 0);
        expect_out("disc.c5", 1, 10'h155, 0, 0); cyc(0, 0, 1, 0, 0);
        expect_out("disc.c6", 1, 10'h155, 0, 0); cyc(1, 10'h155, 1, 0, 0);
        expect_out("disc.c7", 0, 0, 1, 10'h155);

        // ---------------- Redirect coincident with an ack, queue occupied ----------------
        do_reset();
        cyc(0, 0, 0, 0, 0);
        expect_out("coin.c1", 1, 0, 0, 0);      cyc(1, 0, 0, 0, 0);
        expect_out("coin.c2", 0, 0, 1, 0);      cyc(0, 0, 0, 0, 0);
        expect_out("coin.c3", 1, 1, 1, 0);      cyc(1, 1, 0, 1, 10'h2A0);
        expect_out("coin.c4", 1, 10'h2A0, 0, 0); cyc(0, 0, 0, 0, 0);
        expect_out("coin.c5", 1, 10'h2A0, 0, 0); cyc(1, 10'h2A0, 0, 0, 0);
        expect_out("coin.c6", 0, 0, 1, 10'h2A0);

        // ---------------- PC wrap 1023 -> 0 ----------------
        do_reset();
        cyc(0, 0, 0, 1, 10'h3FF);
        expect_out("wrap.c1", 1, 10'h3FF, 0, 0); cyc(1, 10'h3FF, 0, 0, 0);
        expect_out("wrap.c2", 0, 0, 1, 10'h3FF); cyc(0, 0, 1, 0, 0);
        expect_out("wrap.c3", 1, 0, 0, 0);       cyc(1, 0, 0, 0, 0);
        expect_out("wrap.c4", 0, 0, 1, 0);

        // ---------------- Reset pulsed with two queued entries ----------------
        do_reset();
        cyc(0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
        expect_out("rst.pre", 0, 0, 1, 0);
        #2 rst_n = 1'b0;
        #1;
        check("rst.imem_req", imem_req, 1'b0);
        check("rst.imem_addr", imem_addr, '0);
        check("rst.inst_valid", inst_valid, 1'b0);
        check("rst.inst_data", inst_data, '0);
        check("rst.inst_pc", inst_pc, '0);
`ifdef IFETCH_PERF_EN
        check("rst.perf_inst", perf_inst, '0);
        check("rst.perf_flush", perf_flush, '0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        expect_out("rst.c0", 0, 0, 0, 0);       cyc(0, 0, 0, 0, 0);
        expect_out("rst.c1", 1, 0, 0, 0);

        // ---------------- Randomized run against the reference model ----------------
        do_reset();
        q.delete();
        m_pc = '0; m_disc_addr = '0; m_req = 1'b0; m_disc = 1'b0;
        m_perf_inst = 0; m_perf_flush = 0; pops = 0;
        for (int cyc_i = 0; cyc_i < 3000; cyc_i++) begin
            logic ack_v, ready_v, rv, pop, acc, disc_now;
            logic [PC_W-1:0] rpc;
            expect_out($sformatf("rnd%0d", cyc_i), m_req, m_disc ? m_disc_addr : m_pc,
                       q.size() != 0, (q.size() != 0) ? q[0] : '0);
`ifdef IFETCH_PERF_EN
            check("rnd.perf_inst", perf_inst, 32'(m_perf_inst));
            check("rnd.perf_flush", perf_flush, 32'(m_perf_flush));
`endif
            ack_v   = imem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            ready_v = ($urandom_range(0, 3) != 0);
            rv      = ($urandom_range(0, 24) == 0);
            rpc     = ($urandom_range(0, 3) == 0) ? PC_W'($urandom_range(1022, 1023))
                                                  : PC_W'($urandom);
            imem_ack       = ack_v;
            imem_rdata     = ack_v ? word_of(imem_addr) : $urandom;
            inst_ready     = ready_v;
            redirect_valid = rv;
            redirect_pc    = rpc;

            pop = (q.size() != 0) && ready_v;
            acc = m_req && ack_v;
            disc_now = !m_disc && m_req && !ack_v;
            if (pop) begin
                pops++;
                m_perf_inst++;
            end
            if (rv) begin
                if (q.size() != 0 || disc_now) m_perf_flush++;
                if (disc_now) begin
                    m_disc      = 1'b1;
                    m_disc_addr = m_pc;
                end else if (m_disc && ack_v) begin
                    m_disc = 1'b0;
                end
                q.delete();
                m_pc  = rpc;
                m_req = 1'b1;
            end else if (m_disc) begin
                if (ack_v) m_disc = 1'b0;
                m_req = 1'b1;
            end else begin
                if (pop) void'(q.pop_front());
                if (acc) begin
                    q.push_back(m_pc);
                    m_pc  = m_pc + PC_W'(1);
                    m_req = 1'b0;
                end else if (!m_req) begin
                    m_req = (q.size() < DEPTH);
                end
            end
            @(negedge clk);
        end
        imem_ack = 1'b0;
        redirect_valid = 1'b0;
        check("rnd.progress", 32'(pops > 300), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
